// File: rtl/cmos_i2c_responder.sv
// PCF8583-style CMOS RAM I2C responder: filtered SCL/SDA, 256x8 RAM, auto-incrementing pointer.
// Optional host save/restore port enabled by defining CMOS_HOSTPORT_EN.
module cmos_i2c_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clkcpu,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
`ifdef CMOS_HOSTPORT_EN
    input  logic [7:0] host_addr,
    input  logic [7:0] host_din,
    input  logic       host_we,
    output logic [7:0] host_dout,
`endif
    output logic       sda_o,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WORD, WRITE, ACK_WR, READ, ACK_RD
    } state_t;

    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-2:0] scl_hist, sda_hist;
    logic [FILTER_LEN-1:0] scl_win, sda_win;
    logic                  scl_f, sda_f;
    logic                  scl_rise, scl_fall, sda_rise, sda_fall, start, stop;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic [7:0] byte_in;
    logic [7:0] ptr;
    logic       rw, ack_seen, nack, fall_d;
    logic       i2c_we;
    logic [7:0] i2c_waddr, i2c_wdata, rd_data;
    logic [7:0] ram [256];

    // A level is accepted only once the newest FILTER_LEN synchronised samples agree.
    assign scl_win  = {scl_hist, scl_sync[1]};
    assign sda_win  = {sda_hist, sda_sync[1]};
    assign scl_rise = !scl_f && (&scl_win);
    assign scl_fall = scl_f && !(|scl_win);
    assign sda_rise = !sda_f && (&sda_win);
    assign sda_fall = sda_f && !(|sda_win);
    assign start    = sda_fall && scl_f;
    assign stop     = sda_rise && scl_f;
    assign byte_in  = {shift_reg, sda_f};

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= scl_win[FILTER_LEN-2:0];
            sda_hist <= sda_win[FILTER_LEN-2:0];
            if (&scl_win)
                scl_f <= 1'b1;
            else if (!(|scl_win))
                scl_f <= 1'b0;
            if (&sda_win)
                sda_f <= 1'b1;
            else if (!(|sda_win))
                sda_f <= 1'b0;
        end
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state     <= IDLE;
            sda_o     <= 1'b1;
            busy_o    <= 1'b0;
            ptr       <= 8'h00;
            bit_cnt   <= 3'd0;
            shift_reg <= 7'd0;
            rw        <= 1'b0;
            ack_seen  <= 1'b0;
            nack      <= 1'b0;
            fall_d    <= 1'b0;
            i2c_we    <= 1'b0;
            i2c_waddr <= 8'h00;
            i2c_wdata <= 8'h00;
        end else begin
            i2c_we <= 1'b0;
            // A START/STOP coinciding with an SCL edge swallows that edge.
            fall_d <= scl_fall && !start && !stop;
            if (start) begin
                state   <= DEVADDR;
                bit_cnt <= 3'd0;
                sda_o   <= 1'b1;
            end else if (stop) begin
                state  <= IDLE;
                sda_o  <= 1'b1;
                busy_o <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    DEVADDR, WORDADDR, WRITE: begin
                        shift_reg <= byte_in[6:0];
                        bit_cnt   <= bit_cnt + 3'd1;
                        ack_seen  <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            if (state == DEVADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    state  <= ACK_DEV;
                                    rw     <= byte_in[0];
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= IDLE;
                                    busy_o <= 1'b0;
                                end
                            end else if (state == WORDADDR) begin
                                ptr   <= byte_in;
                                state <= ACK_WORD;
                            end else begin
                                i2c_we    <= 1'b1;
                                i2c_waddr <= ptr;
                                i2c_wdata <= byte_in;
                                ptr       <= ptr + 8'd1;
                                state     <= ACK_WR;
                            end
                        end
                    end
                    READ: begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        ack_seen <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            ptr   <= ptr + 8'd1;
                            state <= ACK_RD;
                        end
                    end
                    ACK_DEV, ACK_WORD, ACK_WR: ack_seen <= 1'b1;
                    ACK_RD: begin
                        ack_seen <= 1'b1;
                        nack     <= sda_f;
                    end
                    default: ;
                endcase
            end else if (fall_d) begin
                // The first fall in an ACK state opens the ACK slot, the second closes it.
                case (state)
                    ACK_DEV, ACK_WORD, ACK_WR: begin
                        if (!ack_seen) begin
                            sda_o <= 1'b0;
                        end else begin
                            bit_cnt <= 3'd0;
                            if (state == ACK_DEV && rw) begin
                                state <= READ;
                                sda_o <= rd_data[7];
                            end else begin
                                state <= (state == ACK_DEV) ? WORDADDR : WRITE;
                                sda_o <= 1'b1;
                            end
                        end
                    end
                    READ: sda_o <= rd_data[~bit_cnt];
                    ACK_RD: begin
                        if (!ack_seen) begin
                            sda_o <= 1'b1;
                        end else if (nack) begin
                            state  <= IDLE;
                            sda_o  <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state   <= READ;
                            bit_cnt <= 3'd0;
                            sda_o   <= rd_data[7];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM is deliberately not reset so CMOS contents survive a system reset.
    always_ff @(posedge clkcpu) begin
        if (i2c_we)
            ram[i2c_waddr] <= i2c_wdata;
`ifdef CMOS_HOSTPORT_EN
        if (host_we)
            ram[host_addr] <= host_din;
`endif
        rd_data <= ram[ptr];
    end

`ifdef CMOS_HOSTPORT_EN
    always_ff @(posedge clkcpu) begin
        if (rst_i)
            host_dout <= 8'h00;
        else
            host_dout <= ram[host_addr];
    end
`endif

endmodule

// File: tb/tb_cmos_i2c_responder.sv
// Directed bench for cmos_i2c_responder acting as an I2C initiator on a wired-AND SDA.
// Host-port steps are included when CMOS_HOSTPORT_EN is defined.
module tb_cmos_i2c_responder;

    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic init_sda = 1'b1;
    logic sda_o, busy_o, sda_bus;
    logic [7:0] rd;
    int n_assert = 0;
    int n_fail = 0;
`ifdef CMOS_HOSTPORT_EN
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_din = 8'h00;
    logic       host_we = 1'b0;
    logic [7:0] host_dout;
`endif

    always #5 clk = ~clk;
    assign sda_bus = init_sda & sda_o;

    cmos_i2c_responder dut (
        .clkcpu   (clk),
        .rst_i    (rst),
        .scl_i    (scl),
        .sda_i    (sda_bus),
`ifdef CMOS_HOSTPORT_EN
        .host_addr(host_addr),
        .host_din (host_din),
        .host_we  (host_we),
        .host_dout(host_dout),
`endif
        .sda_o    (sda_o),
        .busy_o   (busy_o)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s_scl, input logic s_sda, input int n);
        scl = s_scl;
        init_sda = s_sda;
        wait_clk(n);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        applyStimulus(1'b0, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b0, 1'b0, Q);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0, Q);
        applyStimulus(1'b1, 1'b0, Q);
        applyStimulus(1'b1, 1'b1, Q);
    endtask

    task automatic send_bit(input logic b);
        applyStimulus(1'b0, b, Q);
        applyStimulus(1'b1, b, Q);
        applyStimulus(1'b0, b, Q);
    endtask

    // Sends a byte and checks the responder's level during the 9th SCL high.
    task automatic write_byte(input logic [7:0] data, input logic exp_ack, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--)
            send_bit(data[i]);
        applyStimulus(1'b0, 1'b1, Q);
        applyStimulus(1'b1, 1'b1, Q);
        ack = sda_bus;
        applyStimulus(1'b0, 1'b1, Q);
        checkOutput(tag, {7'd0, ack}, {7'd0, exp_ack});
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] data);
        data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, Q);
            applyStimulus(1'b1, 1'b1, Q);
            data = {data[6:0], sda_bus};
            applyStimulus(1'b0, 1'b1, Q);
        end
        send_bit(ack_bit);
    endtask

    initial begin
        wait_clk(5);
        checkOutput("reset_sda", {7'd0, sda_o}, 8'h01);
        checkOutput("reset_busy", {7'd0, busy_o}, 8'h00);
`ifdef CMOS_HOSTPORT_EN
        checkOutput("reset_host_dout", host_dout, 8'h00);
`endif
        rst = 1'b0;
        wait_clk(10);

        $display("[TB] preload 0x12 <= 0x3C");
        i2c_start();
        write_byte(8'hA0, 1'b0, "pre_ack_dev");
        write_byte(8'h12, 1'b0, "pre_ack_word");
        write_byte(8'h3C, 1'b0, "pre_ack_data");
        i2c_stop();

        $display("[TB] write 0x10 <= 0x55, 0xAA");
        i2c_start();
        write_byte(8'hA0, 1'b0, "t1_ack_dev");
        checkOutput("t1_busy_active", {7'd0, busy_o}, 8'h01);
        write_byte(8'h10, 1'b0, "t1_ack_word");
        write_byte(8'h55, 1'b0, "t1_ack_d0");
        write_byte(8'hAA, 1'b0, "t1_ack_d1");
        i2c_stop();
        checkOutput("t1_busy_after_stop", {7'd0, busy_o}, 8'h00);
        i2c_start();
        write_byte(8'hA1, 1'b0, "t1_ack_rd");
        read_byte(1'b1, rd);
        checkOutput("t1_ptr_is_0x12", rd, 8'h3C);
        i2c_stop();

        $display("[TB] random read from 0x10");
        i2c_start();
        write_byte(8'hA0, 1'b0, "t2_ack_dev");
        write_byte(8'h10, 1'b0, "t2_ack_word");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t2_ack_rd");
        read_byte(1'b0, rd);
        checkOutput("t2_data0", rd, 8'h55);
        read_byte(1'b1, rd);
        checkOutput("t2_data1", rd, 8'hAA);
        checkOutput("t2_busy_after_nack", {7'd0, busy_o}, 8'h00);
        checkOutput("t2_sda_after_nack", {7'd0, sda_o}, 8'h01);
        i2c_stop();

        $display("[TB] pointer wrap");
        i2c_start();
        write_byte(8'hA0, 1'b0, "t3_ack_dev");
        write_byte(8'hFF, 1'b0, "t3_ack_word");
        write_byte(8'h01, 1'b0, "t3_ack_d0");
        write_byte(8'h02, 1'b0, "t3_ack_d1");
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t3_ack_dev2");
        write_byte(8'hFF, 1'b0, "t3_ack_word2");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t3_ack_rd");
        read_byte(1'b0, rd);
        checkOutput("t3_ram_ff", rd, 8'h01);
        read_byte(1'b1, rd);
        checkOutput("t3_ram_00", rd, 8'h02);
        i2c_stop();

        $display("[TB] address mismatch");
        i2c_start();
        write_byte(8'hA2, 1'b1, "t4_no_ack");
        checkOutput("t4_busy", {7'd0, busy_o}, 8'h00);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t4_ack_dev");
        write_byte(8'h10, 1'b0, "t4_ack_word");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t4_ack_rd");
        read_byte(1'b1, rd);
        checkOutput("t4_ram_unchanged", rd, 8'h55);
        i2c_stop();

        $display("[TB] glitch, aborted byte, reset mid-read");
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_ack_dev");
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, Q);
        write_byte(8'h30, 1'b0, "t5_ack_word");
        write_byte(8'h77, 1'b0, "t5_ack_d0");
        write_byte(8'h44, 1'b0, "t5_ack_d1");
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_ack_dev2");
        write_byte(8'h30, 1'b0, "t5_ack_word2");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_ack_rd");
        read_byte(1'b1, rd);
        checkOutput("t5_no_partial_write", rd, 8'h77);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_ack_rd2");
        read_byte(1'b1, rd);
        checkOutput("t5_after_glitch", rd, 8'h44);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_ack_dev3");
        write_byte(8'h10, 1'b0, "t5_ack_word3");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_ack_rd3");
        checkOutput("t5_driving_bit7", {7'd0, sda_o}, 8'h00);
        rst = 1'b1;
        wait_clk(1);
        checkOutput("t5_sda_after_rst", {7'd0, sda_o}, 8'h01);
        checkOutput("t5_busy_after_rst", {7'd0, busy_o}, 8'h00);
        rst = 1'b0;
        wait_clk(10);
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_ack_after_rst");
        read_byte(1'b1, rd);
        checkOutput("t5_ptr_reset_read", rd, 8'h02);
        i2c_stop();

`ifdef CMOS_HOSTPORT_EN
        $display("[TB] host port");
        host_addr = 8'h20;
        host_din = 8'h5A;
        host_we = 1'b1;
        wait_clk(1);
        host_we = 1'b0;
        i2c_start();
        write_byte(8'hA0, 1'b0, "t6_ack_dev");
        write_byte(8'h20, 1'b0, "t6_ack_word");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t6_ack_rd");
        read_byte(1'b1, rd);
        checkOutput("t6_i2c_sees_host", rd, 8'h5A);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t6_ack_dev2");
        write_byte(8'h21, 1'b0, "t6_ack_word2");
        write_byte(8'h33, 1'b0, "t6_ack_d0");
        i2c_stop();
        host_addr = 8'h21;
        wait_clk(1);
        checkOutput("t6_host_sees_i2c", host_dout, 8'h33);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
